// File: rtl/temp_avg_ctrl.sv
// Averages up to eight 8-bit sensor readings: serial accumulate, then restoring divide.
// Define TEMP_AVG_DIVZERO_FLAG_EN to add div_err_o, flagging a run with no active sensors.
module temp_avg_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] sensors_data_i,
  input  logic [7:0]  sensors_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] temp_Q_o,
  output logic [15:0] temp_R_o,
  output logic [7:0]  active_sensors_nr_o
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
  ,
  output logic        div_err_o
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDiv,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  en_q, en_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] q_out_q, q_out_d;
  logic [15:0] r_out_q, r_out_d;
  logic [7:0]  nr_out_q, nr_out_d;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
  logic        div_err_q, div_err_d;
`endif

  logic [7:0]  sel_data;
  logic [8:0]  rem_shift;
  logic        div_ge;
  logic [7:0]  rem_next;
  logic [15:0] quo_next;

  assign sel_data = data_q[{idx_q, 3'b000} +: 8];

  // Remainder stays below the divisor (<= 8), so 8 bits plus one shift bit suffice.
  assign rem_shift = {rem_q, quo_q[15]};
  assign div_ge    = rem_shift >= {1'b0, cnt_q};
  assign rem_next  = div_ge ? 8'(rem_shift - {1'b0, cnt_q}) : rem_shift[7:0];
  assign quo_next  = {quo_q[14:0], div_ge};

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    en_d      = en_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    nr_out_d  = nr_out_q;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
    div_err_d = div_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          data_d  = sensors_data_i;
          en_d    = sensors_en_i;
          sum_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (en_q[idx_q]) begin
          sum_d = sum_q + {8'b0, sel_data};
          cnt_d = cnt_q + 8'd1;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          if (cnt_d != 8'd0) begin
            rem_d     = '0;
            quo_d     = sum_d;
            div_cnt_d = '0;
            state_d   = StDiv;
          end else begin
            q_out_d   = '0;
            r_out_d   = '0;
            nr_out_d  = '0;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
            div_err_d = 1'b1;
`endif
            state_d   = StDone;
          end
        end
      end
      StDiv: begin
        rem_d     = rem_next;
        quo_d     = quo_next;
        div_cnt_d = div_cnt_q + 4'd1;
        if (div_cnt_q == 4'd15) begin
          q_out_d   = quo_next;
          r_out_d   = {8'b0, rem_next};
          nr_out_d  = cnt_q;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
          div_err_d = 1'b0;
`endif
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      data_q    <= '0;
      en_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      div_cnt_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      nr_out_q  <= '0;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
      div_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      en_q      <= en_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      div_cnt_q <= div_cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      nr_out_q  <= nr_out_d;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
      div_err_q <= div_err_d;
`endif
    end
  end

  assign busy_o              = (state_q != StIdle);
  assign done_o              = (state_q == StDone);
  assign temp_Q_o            = q_out_q;
  assign temp_R_o            = r_out_q;
  assign active_sensors_nr_o = nr_out_q;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
  assign div_err_o           = div_err_q;
`endif

endmodule

// File: tb/tb_temp_avg_ctrl.sv
// Directed bench for temp_avg_ctrl: averages, zero-sensor case, start filtering and abort by reset.
module tb_temp_avg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] data;
  logic [7:0]  en;
  logic        busy;
  logic        done;
  logic [15:0] temp_q;
  logic [15:0] temp_r;
  logic [7:0]  nr;
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
  logic        div_err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  temp_avg_ctrl dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .sensors_data_i      (data),
    .sensors_en_i        (en),
    .busy_o              (busy),
    .done_o              (done),
    .temp_Q_o            (temp_q),
    .temp_R_o            (temp_r),
    .active_sensors_nr_o (nr)
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
    ,
    .div_err_o           (div_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start for one edge, then returns at the negedge where done is seen (or on timeout).
  task automatic run_meas(input logic [63:0] d, input logic [7:0] e, output int lat);
    @(negedge clk);
    data  = d;
    en    = e;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  logic [63:0] d_ramp, d_three, d_max;
  int          lat;
  int          n_done;
  int          first_lat;
  logic [15:0] cap_q, cap_r;
  logic [7:0]  cap_nr;
  int          done_edges[$];
  int          edge_no;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    en    = '0;
    for (int k = 0; k < 8; k++) d_ramp[8*k +: 8] = 8'(20 + k);
    d_three = {8'hAA, 8'h55, 8'hF0, 8'h0F, 8'hCC, 8'd23, 8'd21, 8'd20};
    d_max   = {8{8'hFF}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", temp_q, 0);
    check("rst_r", temp_r, 0);
    check("rst_nr", nr, 0);
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
    check("rst_err", div_err, 0);
`endif
    rst = 1'b0;

    // All eight sensors, 20..27: sum 188 / 8
    run_meas(d_ramp, 8'hFF, lat);
    check("ramp_lat", lat, 24);
    check("ramp_busy", busy, 1);
    check("ramp_q", temp_q, 23);
    check("ramp_r", temp_r, 4);
    check("ramp_nr", nr, 8);
    @(negedge clk);
    check("ramp_done_pulse", done, 0);
    check("ramp_idle", busy, 0);
    data = '0;
    repeat (3) @(negedge clk);
    check("ramp_hold_q", temp_q, 23);
    check("ramp_hold_r", temp_r, 4);

    // Sensors 0..2 only: 64 / 3
    run_meas(d_three, 8'b0000_0111, lat);
    check("three_lat", lat, 24);
    check("three_q", temp_q, 21);
    check("three_r", temp_r, 1);
    check("three_nr", nr, 3);

    // No active sensors
    run_meas(d_ramp, 8'h00, lat);
    check("zero_lat", lat, 8);
    check("zero_q", temp_q, 0);
    check("zero_r", temp_r, 0);
    check("zero_nr", nr, 0);
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
    check("zero_err", div_err, 1);
`endif

    // Maximum sum 2040 / 8
    run_meas(d_max, 8'hFF, lat);
    check("max_lat", lat, 24);
    check("max_q", temp_q, 255);
    check("max_r", temp_r, 0);
    check("max_nr", nr, 8);
`ifdef TEMP_AVG_DIVZERO_FLAG_EN
    check("max_err", div_err, 0);
`endif

    // Inputs change after start and start re-pulsed during DIV: one done, original snapshot
    @(negedge clk);
    data  = d_ramp;
    en    = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    data      = d_max;
    en        = 8'h01;
    n_done    = 0;
    first_lat = 0;
    cap_q     = '0;
    cap_r     = '0;
    cap_nr    = '0;
    for (int i = 1; i <= 70; i++) begin
      start = (i == 12);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_lat = i;
          cap_q     = temp_q;
          cap_r     = temp_r;
          cap_nr    = nr;
        end
      end
    end
    start = 1'b0;
    check("snap_ndone", n_done, 1);
    check("snap_lat", first_lat, 24);
    check("snap_q", cap_q, 23);
    check("snap_r", cap_r, 4);
    check("snap_nr", cap_nr, 8);

    // Reset on the fifth DIV edge aborts the run
    @(negedge clk);
    data  = d_three;
    en    = 8'b0000_0111;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", temp_q, 0);
    check("abort_r", temp_r, 0);
    check("abort_nr", nr, 0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_meas(d_three, 8'b0000_0111, lat);
    check("after_abort_lat", lat, 24);
    check("after_abort_q", temp_q, 21);
    check("after_abort_r", temp_r, 1);

    // start held high: back-to-back runs, 26 edges apart
    @(negedge clk);
    data    = d_ramp;
    en      = 8'hFF;
    start   = 1'b1;
    edge_no = 0;
    while (done_edges.size() < 2 && edge_no < 100) begin
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      if (done) done_edges.push_back(edge_no);
    end
    start = 1'b0;
    check("hold_ndone", done_edges.size(), 2);
    if (done_edges.size() == 2) begin
      check("hold_first", done_edges[0], 25);
      check("hold_gap", done_edges[1] - done_edges[0], 26);
    end
    check("hold_q", temp_q, 23);
    repeat (30) @(negedge clk);
    check("hold_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
